sata_cmd_issuer: RTL

SATA_CMD_ISSUER -- requirements
Module: sata_cmd_issuer

---
 rtl/sata_cmd_pkg.sv | 21 ++
 rtl/sata_timeout_cnt.sv | 34 +++
 rtl/sata_cmd_issuer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sata_cmd_pkg.sv
// rtl/sata_cmd_pkg.sv - shared state, shadow-register address and completion-code definitions
package sata_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE, WR0, WR1, WR2, WR3, WAIT_IPF, RD_STAT, CAP_STAT, DONE
  } state_t;

  localparam logic [4:0] ADDR_FEAT       = 5'h01;
  localparam logic [4:0] ADDR_LBA_LO     = 5'h02;
  localparam logic [4:0] ADDR_CNT_LBA_HI = 5'h03;
  localparam logic [4:0] ADDR_CMD_STAT   = 5'h07;

  localparam logic [1:0] CODE_OK        = 2'd0;
  localparam logic [1:0] CODE_DEV_ERR   = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT   = 2'd2;
  localparam logic [1:0] CODE_LINK_LOST = 2'd3;

  localparam int STAT_ERR_BIT = 0;
  localparam int STAT_DF_BIT  = 5;

endpackage

// File: rtl/sata_timeout_cnt.sv
// rtl/sata_timeout_cnt.sv - free-running wait counter that flags the last allowed cycle
module sata_timeout_cnt #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd150000000
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = enable && (cnt_q == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/sata_cmd_issuer.sv
// rtl/sata_cmd_issuer.sv - issues one ATA command through the shadow registers and reports completion
module sata_cmd_issuer
  import sata_cmd_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd150000000,
  parameter logic [7:0]  DEV_BYTE       = 8'h40
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        linkup,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [47:0] cmd_lba,
  input  logic [15:0] cmd_count,
  input  logic [15:0] cmd_features,
  input  logic        cmd_dma,
  output logic        host_write_en,
  output logic        host_read_en,
  output logic [4:0]  host_addr_reg,
  output logic [31:0] host_data_out,
  input  logic [31:0] host_data_in,
  input  logic        write_hold,
  input  logic        ipf,
  output logic        dma_rqst,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [7:0]  done_status,
  output logic [1:0]  done_code
);

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [47:0] lba_q, lba_d;
  logic [15:0] count_q, count_d;
  logic [15:0] features_q, features_d;
  logic        dma_q, dma_d;
  logic [7:0]  status_q, status_d;
  logic [1:0]  code_q, code_d;

  logic        wr_state;
  logic        link_abort;
  logic        timeout_hit;
  logic        unused_data_hi;

  assign unused_data_hi = ^host_data_in[31:8];

  sata_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (state_q != WAIT_IPF),
    .enable  (state_q == WAIT_IPF),
    .hit     (timeout_hit)
  );

  assign wr_state   = state_q inside {WR0, WR1, WR2, WR3};
  assign link_abort = !linkup && (state_q inside {WR0, WR1, WR2, WR3, WAIT_IPF, RD_STAT, CAP_STAT});

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    lba_d      = lba_q;
    count_d    = count_q;
    features_d = features_q;
    dma_d      = dma_q;
    status_d   = status_q;
    code_d     = code_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && linkup) begin
          opcode_d   = cmd_opcode;
          lba_d      = cmd_lba;
          count_d    = cmd_count;
          features_d = cmd_features;
          dma_d      = cmd_dma;
          status_d   = 8'h00;
          code_d     = CODE_OK;
          state_d    = WR0;
        end
      end
      WR0: if (!write_hold) state_d = WR1;
      WR1: if (!write_hold) state_d = WR2;
      WR2: if (!write_hold) state_d = WR3;
      WR3: if (!write_hold) state_d = WAIT_IPF;
      WAIT_IPF: begin
        if (ipf) begin
          state_d = RD_STAT;
        end else if (timeout_hit) begin
          status_d = 8'h00;
          code_d   = CODE_TIMEOUT;
          state_d  = DONE;
        end
      end
      RD_STAT: state_d = CAP_STAT;
      CAP_STAT: begin
        status_d = host_data_in[7:0];
        code_d   = (host_data_in[STAT_ERR_BIT] || host_data_in[STAT_DF_BIT]) ? CODE_DEV_ERR : CODE_OK;
        state_d  = DONE;
      end
      DONE: begin
        if (done_ready) begin
          dma_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Losing the link overrides whatever the active state decided this cycle.
    if (link_abort) begin
      status_d = 8'h00;
      code_d   = CODE_LINK_LOST;
      state_d  = DONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      lba_q      <= '0;
      count_q    <= '0;
      features_q <= '0;
      dma_q      <= 1'b0;
      status_q   <= '0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      lba_q      <= lba_d;
      count_q    <= count_d;
      features_q <= features_d;
      dma_q      <= dma_d;
      status_q   <= status_d;
      code_q     <= code_d;
    end
  end

  // Strobes are gated combinationally so HOLD and link loss take effect in the same cycle.
  assign host_write_en = wr_state && !write_hold && linkup;
  assign host_read_en  = (state_q == RD_STAT) && linkup;
  assign cmd_ready     = (state_q == IDLE) && linkup && aresetn;
  assign dma_rqst      = dma_q;
  assign done_valid    = (state_q == DONE);
  assign done_status   = status_q;
  assign done_code     = code_q;

  always_comb begin
    host_addr_reg = '0;
    host_data_out = '0;
    case (state_q)
      WR0: begin
        host_addr_reg = ADDR_FEAT;
        host_data_out = {features_q, DEV_BYTE, 8'h00};
      end
      WR1: begin
        host_addr_reg = ADDR_LBA_LO;
        host_data_out = lba_q[31:0];
      end
      WR2: begin
        host_addr_reg = ADDR_CNT_LBA_HI;
        host_data_out = {count_q, lba_q[47:32]};
      end
      WR3: begin
        host_addr_reg = ADDR_CMD_STAT;
        host_data_out = {24'h0, opcode_q};
      end
      RD_STAT: host_addr_reg = ADDR_CMD_STAT;
      default: ;
    endcase
  end

endmodule
